// File: rtl/sc_nor_gate_checker.sv
// Drives all four a/b combinations onto a 2-input NOR gate and checks the gate output.
// Reports pass/fail, a mismatch count and a per-vector failure map after each run.
module sc_nor_gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       sc_nor_gate_checker_CLOCK_50,
  input  logic       sc_nor_gate_checker_RESET_InHigh,
  input  logic       sc_nor_gate_checker_start_In,
  input  logic       sc_nor_gate_checker_z_In,
  output logic       sc_nor_gate_checker_a_Out,
  output logic       sc_nor_gate_checker_b_Out,
  output logic       sc_nor_gate_checker_busy_Out,
  output logic       sc_nor_gate_checker_done_Out,
  output logic       sc_nor_gate_checker_pass_Out,
  output logic [2:0] sc_nor_gate_checker_errcount_Out,
  output logic [3:0] sc_nor_gate_checker_failvec_Out
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} stateT;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  stateT      state, stateNext;
  logic [1:0] vecIdx, vecIdxNext;
  logic [3:0] settleCnt, settleCntNext;
  logic       aReg, aNext, bReg, bNext;
  logic       passReg, passNext;
  logic [2:0] errCnt, errCntNext;
  logic [3:0] failVec, failVecNext;
  logic       mismatch;

  // NOR truth table: only vector 0 (a=0, b=0) yields 1.
  function automatic logic expectedZ(input logic [1:0] idx);
    return ~(idx[1] | idx[0]);
  endfunction

  // At most four mismatches per run, so the count saturates instead of wrapping.
  function automatic logic [2:0] satInc(input logic [2:0] cnt);
    return (cnt >= 3'd4) ? 3'd4 : cnt + 3'd1;
  endfunction

  assign mismatch = (sc_nor_gate_checker_z_In != expectedZ(vecIdx));

  always_comb begin
    stateNext     = state;
    vecIdxNext    = vecIdx;
    settleCntNext = settleCnt;
    aNext         = aReg;
    bNext         = bReg;
    passNext      = passReg;
    errCntNext    = errCnt;
    failVecNext   = failVec;
    case (state)
      IDLE: begin
        if (sc_nor_gate_checker_start_In) begin
          errCntNext    = 3'd0;
          failVecNext   = 4'd0;
          passNext      = 1'b0;
          vecIdxNext    = 2'd0;
          settleCntNext = 4'd0;
          aNext         = 1'b0;
          bNext         = 1'b0;
          stateNext     = DRIVE;
        end
      end
      DRIVE: begin
        if (settleCnt == LAST_CNT) begin
          if (mismatch) begin
            failVecNext[vecIdx] = 1'b1;
            errCntNext          = satInc(errCnt);
          end
          if (vecIdx == 2'd3) begin
            aNext     = 1'b0;
            bNext     = 1'b0;
            passNext  = (errCntNext == 3'd0);
            stateNext = DONE;
          end else begin
            vecIdxNext    = vecIdx + 2'd1;
            settleCntNext = 4'd0;
            aNext         = vecIdxNext[1];
            bNext         = vecIdxNext[0];
          end
        end else begin
          settleCntNext = settleCnt + 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sc_nor_gate_checker_CLOCK_50) begin
    if (sc_nor_gate_checker_RESET_InHigh) begin
      state     <= IDLE;
      vecIdx    <= 2'd0;
      settleCnt <= 4'd0;
      aReg      <= 1'b0;
      bReg      <= 1'b0;
      passReg   <= 1'b0;
      errCnt    <= 3'd0;
      failVec   <= 4'd0;
    end else begin
      state     <= stateNext;
      vecIdx    <= vecIdxNext;
      settleCnt <= settleCntNext;
      aReg      <= aNext;
      bReg      <= bNext;
      passReg   <= passNext;
      errCnt    <= errCntNext;
      failVec   <= failVecNext;
    end
  end

  assign sc_nor_gate_checker_a_Out        = aReg;
  assign sc_nor_gate_checker_b_Out        = bReg;
  assign sc_nor_gate_checker_busy_Out     = (state == DRIVE);
  assign sc_nor_gate_checker_done_Out     = (state == DONE);
  assign sc_nor_gate_checker_pass_Out     = passReg;
  assign sc_nor_gate_checker_errcount_Out = errCnt;
  assign sc_nor_gate_checker_failvec_Out  = failVec;

endmodule

// File: tb/tb_sc_nor_gate_checker.sv
// Bench for sc_nor_gate_checker: two instances (settle 2 and settle 1) exercised against
// ideal, stuck-at and inverted gate models, with randomized runs.
module tb_sc_nor_gate_checker;

  localparam int SET0 = 2;
  localparam int SET1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       startIn [2];
  logic       zIn     [2];
  logic       aOut    [2];
  logic       bOut    [2];
  logic       busyOut [2];
  logic       doneOut [2];
  logic       passOut [2];
  logic [2:0] errOut  [2];
  logic [3:0] failOut [2];
  int         zMode   [2];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sc_nor_gate_checker #(.SETTLE_CYCLES(SET0)) dut0 (
    .sc_nor_gate_checker_CLOCK_50(clk),
    .sc_nor_gate_checker_RESET_InHigh(rst),
    .sc_nor_gate_checker_start_In(startIn[0]),
    .sc_nor_gate_checker_z_In(zIn[0]),
    .sc_nor_gate_checker_a_Out(aOut[0]),
    .sc_nor_gate_checker_b_Out(bOut[0]),
    .sc_nor_gate_checker_busy_Out(busyOut[0]),
    .sc_nor_gate_checker_done_Out(doneOut[0]),
    .sc_nor_gate_checker_pass_Out(passOut[0]),
    .sc_nor_gate_checker_errcount_Out(errOut[0]),
    .sc_nor_gate_checker_failvec_Out(failOut[0])
  );

  sc_nor_gate_checker #(.SETTLE_CYCLES(SET1)) dut1 (
    .sc_nor_gate_checker_CLOCK_50(clk),
    .sc_nor_gate_checker_RESET_InHigh(rst),
    .sc_nor_gate_checker_start_In(startIn[1]),
    .sc_nor_gate_checker_z_In(zIn[1]),
    .sc_nor_gate_checker_a_Out(aOut[1]),
    .sc_nor_gate_checker_b_Out(bOut[1]),
    .sc_nor_gate_checker_busy_Out(busyOut[1]),
    .sc_nor_gate_checker_done_Out(doneOut[1]),
    .sc_nor_gate_checker_pass_Out(passOut[1]),
    .sc_nor_gate_checker_errcount_Out(errOut[1]),
    .sc_nor_gate_checker_failvec_Out(failOut[1])
  );

  // Gate under test: 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1, 3 OR (inverted output).
  function automatic logic gateModel(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~(a | b);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a | b;
    endcase
  endfunction

  always_comb begin
    zIn[0] = gateModel(zMode[0], aOut[0], bOut[0]);
    zIn[1] = gateModel(zMode[1], aOut[1], bOut[1]);
  end

  // Reference: mismatches of the gate model against the NOR truth table over vectors below lim.
  function automatic int refErrors(input int mode, input int lim);
    int n = 0;
    for (int i = 0; i < lim; i++)
      if (gateModel(mode, (i / 2) != 0, (i % 2) != 0) !== ((i == 0) ? 1'b1 : 1'b0)) n++;
    return n;
  endfunction

  function automatic logic [3:0] refFail(input int mode);
    logic [3:0] f = 4'd0;
    for (int i = 0; i < 4; i++)
      if (gateModel(mode, (i / 2) != 0, (i % 2) != 0) !== ((i == 0) ? 1'b1 : 1'b0)) f[i] = 1'b1;
    return f;
  endfunction

  // Full run from IDLE; caller must be at a negedge with the unit idle.
  task automatic test_run(input int u, input int mode, input bit midStart);
    int         s = (u == 0) ? SET0 : SET1;
    int         expErr = refErrors(mode, 4);
    logic [3:0] expFail = refFail(mode);
    logic [1:0] v;
    logic [3:0] act, exp;
    zMode[u]   = mode;
    startIn[u] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4 * s; k++) begin
      startIn[u] = midStart && (k == 2);
      v   = 2'(k / s);
      act = {busyOut[u], doneOut[u], aOut[u], bOut[u]};
      exp = {1'b1, 1'b0, v[1], v[0]};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL drive u%0d mode%0d k%0d: {busy,done,a,b} got %b want %b", u, mode, k, act, exp);
      end
      if (k == 0) begin
        checks++;
        if ({errOut[u], failOut[u], passOut[u]} !== 8'd0) begin
          errors++;
          $display("FAIL clear_on_start u%0d: err=%0d fail=%b pass=%b want 0/0000/0",
                   u, errOut[u], failOut[u], passOut[u]);
        end
      end
      @(negedge clk);
    end
    startIn[u] = 1'b0;
    checks++;
    if ({busyOut[u], doneOut[u], aOut[u], bOut[u]} !== 4'b0100) begin
      errors++;
      $display("FAIL done_pulse u%0d: {busy,done,a,b} got %b want 0100",
               u, {busyOut[u], doneOut[u], aOut[u], bOut[u]});
    end
    checks++;
    if (errOut[u] !== 3'(expErr) || failOut[u] !== expFail || passOut[u] !== (expErr == 0)) begin
      errors++;
      $display("FAIL result u%0d mode%0d: err=%0d fail=%b pass=%b want err=%0d fail=%b pass=%b",
               u, mode, errOut[u], failOut[u], passOut[u], expErr, expFail, (expErr == 0));
    end
    @(negedge clk);
    checks++;
    if ({busyOut[u], doneOut[u], aOut[u], bOut[u]} !== 4'b0000 ||
        errOut[u] !== 3'(expErr) || failOut[u] !== expFail || passOut[u] !== (expErr == 0)) begin
      errors++;
      $display("FAIL idle_hold u%0d: {busy,done,a,b}=%b err=%0d fail=%b pass=%b want 0000/%0d/%b/%b",
               u, {busyOut[u], doneOut[u], aOut[u], bOut[u]}, errOut[u], failOut[u], passOut[u],
               expErr, expFail, (expErr == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({aOut[u], bOut[u], busyOut[u], doneOut[u], passOut[u], errOut[u], failOut[u]} !== 12'd0) begin
        errors++;
        $display("FAIL reset u%0d: a=%b b=%b busy=%b done=%b pass=%b err=%0d fail=%b want all 0",
                 u, aOut[u], bOut[u], busyOut[u], doneOut[u], passOut[u], errOut[u], failOut[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int sawDone = 0;
    zMode[0]   = 3;
    startIn[0] = 1'b1;
    @(negedge clk);
    startIn[0] = 1'b0;
    repeat (2 * SET0) @(negedge clk);
    checks++;
    if ({aOut[0], bOut[0]} !== 2'b10 || errOut[0] !== 3'(refErrors(3, 2))) begin
      errors++;
      $display("FAIL abort_pre u0: ab=%b err=%0d want ab=10 err=%0d",
               {aOut[0], bOut[0]}, errOut[0], refErrors(3, 2));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({aOut[0], bOut[0], busyOut[0], doneOut[0], passOut[0], errOut[0], failOut[0]} !== 12'd0) begin
      errors++;
      $display("FAIL abort_reset u0: a=%b b=%b busy=%b done=%b pass=%b err=%0d fail=%b want all 0",
               aOut[0], bOut[0], busyOut[0], doneOut[0], passOut[0], errOut[0], failOut[0]);
    end
    for (int k = 0; k < 4 * SET0 + 2; k++) begin
      if (doneOut[0] !== 1'b0 || busyOut[0] !== 1'b0) sawDone++;
      @(negedge clk);
    end
    checks++;
    if (sawDone != 0) begin
      errors++;
      $display("FAIL abort_quiet u0: busy/done active in %0d cycles want 0", sawDone);
    end
    test_run(0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_run(0, 3, 1'b0);
    test_run(0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      test_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst        = 1'b1;
    startIn[0] = 1'b0;
    startIn[1] = 1'b0;
    zMode[0]   = 0;
    zMode[1]   = 0;
    @(negedge clk);
    test_reset();
    test_run(0, 0, 1'b0);
    test_run(0, 1, 1'b0);
    test_run(0, 2, 1'b0);
    test_run(0, 3, 1'b0);
    test_run(0, 0, 1'b1);
    test_back_to_back();
    test_reset_abort();
    test_run(1, 0, 1'b0);
    test_run(1, 3, 1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_nor_gate_checker.md
# sc_nor_gate_checker

Sequential stimulus/response block for the team's 2-input NOR gate interface (a, b in; z out). On a start pulse it drives all four a/b combinations onto the gate inputs, samples the gate output after a programmable settle time, compares it with the NOR truth table, and reports a pass/fail flag, an error count and a per-vector failure map. It sits on the board-level test harness next to the combinational gate it exercises, closing the loop from the driver side.

## Interface
- SETTLE_CYCLES, default 2: cycles each input vector is held before z is sampled; legal range 1..15.
- sc_nor_gate_checker_CLOCK_50  input  1  system clock; all logic on rising edge.
- sc_nor_gate_checker_RESET_InHigh  input  1  reset, synchronous, active-high.
- sc_nor_gate_checker_start_In  input  1  start request; honoured only in IDLE.
- sc_nor_gate_checker_z_In  input  1  gate output under test.
- sc_nor_gate_checker_a_Out  output  1  gate input a (registered).
- sc_nor_gate_checker_b_Out  output  1  gate input b (registered).
- sc_nor_gate_checker_busy_Out  output  1  high while vectors are being driven.
- sc_nor_gate_checker_done_Out  output  1  one-cycle pulse when a run completes.
- sc_nor_gate_checker_pass_Out  output  1  1 = last completed run had zero mismatches.
- sc_nor_gate_checker_errcount_Out  output  3  mismatches in last run (0..4).
- sc_nor_gate_checker_failvec_Out  output  4  bit i set = vector i mismatched.

## Operation
- Vector index i = 0..3; a = i[1], b = i[0]; expected z = ~(a | b), i.e. 1 only for i = 0.
- States: IDLE, DRIVE, DONE.
- IDLE: a = b = 0, busy = 0. On start = 1: clear errcount, failvec, pass; load i = 0, settle counter = 0; go DRIVE.
- DRIVE: busy = 1; a/b reflect current i. Settle counter increments each cycle. On the edge where counter == SETTLE_CYCLES-1: sample z_In, compare with expected; on mismatch set failvec[i], errcount += 1. Then if i < 3: i += 1, counter = 0, stay DRIVE; if i == 3: go DONE.
- DONE (one cycle): busy = 0, done = 1, pass = (errcount == 0), a = b = 0; next state IDLE.
- errcount, failvec, pass hold their values in IDLE until the next accepted start.
- start while in DRIVE or DONE is ignored (no restart, no queueing).
- errcount is 3 bits; maximum value 4, no wrap.

## Timing
- Reset (synchronous, RESET_InHigh = 1 at a rising edge): state IDLE; a = b = 0, busy = 0, done = 0, pass = 0, errcount = 0, failvec = 0000. Reset overrides start and aborts a run in progress with no done pulse.
- Start sampled high at edge T0 -> busy = 1, a/b = vector 0 visible after T0.
- Each vector held exactly SETTLE_CYCLES cycles; z sampled at the last edge of its hold window (z_In must be stable SETTLE_CYCLES-1 cycles after a/b change).
- busy high for 4*SETTLE_CYCLES cycles; done pulse in the following cycle; earliest next accepted start is the cycle after done.
- errcount/failvec update at the sampling edge; pass updates at entry to DONE (valid together with done).

## Test plan
- Ideal NOR model on z_In, SETTLE_CYCLES = 2, start pulse -> busy for 8 cycles, a/b sequence 00,00,01,01,10,10,11,11, done pulse 1 cycle, pass = 1, errcount = 0, failvec = 0000.
- z_In stuck at 0 -> pass = 0, errcount = 1, failvec = 0001; stuck at 1 -> errcount = 3, failvec = 1110.
- OR gate (inverted output) on z_In -> errcount = 4, failvec = 1111, pass = 0, no wrap of errcount.
- start pulsed again mid-run (cycle 3 of busy) -> ignored; run completes at normal time; second start after done clears results and reruns cleanly.
- Reset asserted one cycle during DRIVE (vector 2) -> next cycle all outputs at reset values, no done pulse; subsequent start performs a full run.
- SETTLE_CYCLES = 1 with ideal NOR -> busy exactly 4 cycles, one vector per cycle, pass = 1.
